relu_maxpool_layer: RTL and testbench

- Streaming post-processing stage that sits directly downstream of the 3x3 convolution stage.
- Consumes one signed 32-bit convolution result per valid cycle in raster order, applies ReLU, and performs 2x2 max pooling with stride 2.
- Emits one pooled value per 2x2 window, using a half-row line buffer.
- Its output stream feeds the next layer or the result collector.

---
 rtl/relu_maxpool_layer_if.sv | 30 +++
 rtl/relu_maxpool_layer.sv | 143 ++++++++++++++
 tb/tb_relu_maxpool_layer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/relu_maxpool_layer_if.sv
// -----------------------------------------------------------------------------
// relu_maxpool_layer_if
// Stream bundle between the convolution stage, the ReLU / 2x2 max-pool stage
// and its consumer.
//   data_in      : signed 32-bit convolution result (two's complement)
//   valid        : data_in is accepted on the rising clock edge when high
//   frame_start  : qualifies data_in as pixel (row 0, col 0) when valid is high
//   pool_out     : pooled, non-negative result; holds between pulses
//   pool_valid   : one-cycle pulse, pool_out is new this cycle
//   frame_done   : one-cycle pulse with the last pool_valid of a frame
// The producer side uses the master modport, the pooling stage the slave one.
// -----------------------------------------------------------------------------
interface relu_maxpool_layer_if;
    logic [31:0] data_in;
    logic        valid;
    logic        frame_start;
    logic [31:0] pool_out;
    logic        pool_valid;
    logic        frame_done;

    modport master (
        output data_in, valid, frame_start,
        input  pool_out, pool_valid, frame_done
    );

    modport slave (
        input  data_in, valid, frame_start,
        output pool_out, pool_valid, frame_done
    );
endinterface

// File: rtl/relu_maxpool_layer.sv
// -----------------------------------------------------------------------------
// relu_maxpool_layer
// Streaming ReLU followed by 2x2 max pooling with stride 2. Pixels arrive in
// raster order, one per valid cycle, with no backpressure. Horizontal pairs
// are reduced through a hold register; even-row pair maxima are parked in a
// half-row line buffer and merged with the matching odd-row pair maximum.
// Ports:
//   clk    : single clock, rising-edge active
//   reset  : asynchronous, active-high; clears counters, hold register,
//            line buffer and outputs
//   bus    : relu_maxpool_layer_if.slave (data_in/valid/frame_start in,
//            pool_out/pool_valid/frame_done out, all outputs registered)
// Parameters:
//   IMG_WIDTH  : pixels per row, even, >= 2
//   IMG_HEIGHT : rows per frame, even, >= 2
// -----------------------------------------------------------------------------
module relu_maxpool_layer #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    relu_maxpool_layer_if.slave  bus
);

    localparam int COL_W    = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W    = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
    localparam int LB_DEPTH = IMG_WIDTH / 2;
    localparam int LB_W     = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;
    logic [31:0]      h_r;
    logic [31:0]      linebuf_r [LB_DEPTH];
    logic [31:0]      pool_out_r;
    logic             pool_valid_r;
    logic             frame_done_r;

    logic [COL_W-1:0] eff_col_s;
    logic [ROW_W-1:0] eff_row_s;
    logic [COL_W-1:0] next_col_s;
    logic [ROW_W-1:0] next_row_s;
    logic [31:0]      relu_s;
    logic [31:0]      pair_max_s;
    logic [31:0]      lb_rd_s;
    logic [31:0]      win_max_s;
    logic [LB_W-1:0]  lb_idx_s;
    logic             last_col_s;
    logic             last_row_s;
    logic             win_done_s;

    // Position of the pixel on the bus, ReLU, pair/window maxima and next position.
    always_comb begin
        eff_col_s  = col_r;
        eff_row_s  = row_r;
        next_col_s = col_r;
        next_row_s = row_r;

        // frame_start forces the pixel to (0,0), abandoning any partial window
        if (bus.frame_start) begin
            eff_col_s = '0;
            eff_row_s = '0;
        end else begin
            eff_col_s = col_r;
            eff_row_s = row_r;
        end

        relu_s     = bus.data_in[31] ? 32'd0 : bus.data_in;
        pair_max_s = (relu_s > h_r) ? relu_s : h_r;
        lb_idx_s   = LB_W'(eff_col_s >> 1'b1);
        lb_rd_s    = linebuf_r[lb_idx_s];
        win_max_s  = (lb_rd_s > pair_max_s) ? lb_rd_s : pair_max_s;

        last_col_s = (eff_col_s == COL_LAST);
        last_row_s = (eff_row_s == ROW_LAST);
        // a window completes on the odd column of an odd row
        win_done_s = eff_col_s[0] & eff_row_s[0];

        if (last_col_s) begin
            next_col_s = '0;
            if (last_row_s) begin
                next_row_s = '0;
            end else begin
                next_row_s = eff_row_s + ROW_ONE;
            end
        end else begin
            next_col_s = eff_col_s + COL_ONE;
            next_row_s = eff_row_s;
        end
    end

    // Position counters, horizontal hold register and half-row line buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_r <= '0;
            row_r <= '0;
            h_r   <= 32'd0;
            for (int i = 0; i < LB_DEPTH; i++) begin
                linebuf_r[i] <= 32'd0;
            end
        end else if (bus.valid) begin
            col_r <= next_col_s;
            row_r <= next_row_s;
            if (!eff_col_s[0]) begin
                h_r <= relu_s;
            end else if (!eff_row_s[0]) begin
                linebuf_r[lb_idx_s] <= pair_max_s;
            end else begin
                h_r <= h_r;
            end
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

    // Registered pooled result with single-cycle valid / frame-done pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pool_out_r   <= 32'd0;
            pool_valid_r <= 1'b0;
            frame_done_r <= 1'b0;
        end else if (bus.valid && win_done_s) begin
            pool_out_r   <= win_max_s;
            pool_valid_r <= 1'b1;
            frame_done_r <= last_col_s & last_row_s;
        end else begin
            pool_out_r   <= pool_out_r;
            pool_valid_r <= 1'b0;
            frame_done_r <= 1'b0;
        end
    end

    assign bus.pool_out   = pool_out_r;
    assign bus.pool_valid = pool_valid_r;
    assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_relu_maxpool_layer.sv
// -----------------------------------------------------------------------------
// tb_relu_maxpool_layer
// Directed self-checking bench for relu_maxpool_layer on a 4x4 frame.
// A negedge monitor collects every pool_valid pulse (value + frame_done) and
// each scenario compares the collected list with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_relu_maxpool_layer;

    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    logic clk = 1'b0;
    logic reset;

    relu_maxpool_layer_if bus ();

    relu_maxpool_layer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] q_val [$];
    logic        q_fd  [$];
    logic [31:0] model_out;
    logic [31:0] exp_v [8];
    logic        exp_f [8];
    int          frame_px [N];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
        end
    endtask

    // collect output pulses away from the active edge
    always @(negedge clk) begin
        if (bus.pool_valid === 1'b1) begin
            q_val.push_back(bus.pool_out);
            q_fd.push_back(bus.frame_done);
        end
    end

    function automatic logic [31:0] relu(input int v);
        return (v < 0) ? 32'd0 : 32'(v);
    endfunction

    // reference: window ending at raster index k covers k, k-1, k-W, k-W-1
    function automatic logic [31:0] window_max(input int k);
        logic [31:0] m;
        m = relu(frame_px[k]);
        if (relu(frame_px[k-1]) > m)   m = relu(frame_px[k-1]);
        if (relu(frame_px[k-W]) > m)   m = relu(frame_px[k-W]);
        if (relu(frame_px[k-W-1]) > m) m = relu(frame_px[k-W-1]);
        return m;
    endfunction

    task automatic pix(input int v, input logic fs);
        bus.data_in     = 32'(v);
        bus.valid       = 1'b1;
        bus.frame_start = fs;
        @(posedge clk);
        #1;
        bus.valid       = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_val("gap_pool_valid", {31'd0, bus.pool_valid}, 32'd0);
            check_val("gap_frame_done", {31'd0, bus.frame_done}, 32'd0);
            check_val("gap_pool_out_hold", bus.pool_out, model_out);
        end
    endtask

    task automatic send_frame(input int n_px, input int max_gap, input logic fs_first);
        for (int k = 0; k < n_px; k++) begin
            pix(frame_px[k], (k == 0) ? fs_first : 1'b0);
            if (((k / W) % 2 == 1) && ((k % W) % 2 == 1)) begin
                model_out = window_max(k);
            end
            if (max_gap > 0) begin
                idle(int'($urandom_range(max_gap, 0)));
            end
        end
    endtask

    task automatic set_frame(input int mode);
        for (int k = 0; k < N; k++) begin
            case (mode)
                0:       frame_px[k] = k + 1;
                1:       frame_px[k] = N - k;
                2:       frame_px[k] = -(k + 1);
                default: frame_px[k] = 0;
            endcase
        end
    endtask

    task automatic set_exp4(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d);
        exp_v[0] = a; exp_v[1] = b; exp_v[2] = c; exp_v[3] = d;
        exp_f[0] = 1'b0; exp_f[1] = 1'b0; exp_f[2] = 1'b0; exp_f[3] = 1'b1;
    endtask

    task automatic expect_outs(input int n, input string tag);
        @(negedge clk);
        #1;
        check_val($sformatf("%s_count", tag), 32'(q_val.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < q_val.size()) begin
                check_val($sformatf("%s_val%0d", tag, i), q_val[i], exp_v[i]);
                check_val($sformatf("%s_fd%0d", tag, i), {31'd0, q_fd[i]}, {31'd0, exp_f[i]});
            end
        end
        q_val.delete();
        q_fd.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val($sformatf("%s_pool_out", tag), bus.pool_out, 32'd0);
        check_val($sformatf("%s_pool_valid", tag), {31'd0, bus.pool_valid}, 32'd0);
        check_val($sformatf("%s_frame_done", tag), {31'd0, bus.frame_done}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        bus.data_in     = 32'd0;
        bus.valid       = 1'b0;
        bus.frame_start = 1'b0;
        model_out       = 32'd0;
        reset           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // ascending 1..16, continuous, frame_start on first pixel
        set_frame(0);
        send_frame(N, 0, 1'b1);
        set_exp4(32'd6, 32'd8, 32'd14, 32'd16);
        expect_outs(4, "asc");

        // all negative frame
        set_frame(2);
        send_frame(N, 0, 1'b0);
        set_exp4(32'd0, 32'd0, 32'd0, 32'd0);
        expect_outs(4, "neg");

        // mixed window {-5, 3, -7, 2}, rest negative
        set_frame(2);
        frame_px[0] = -5;
        frame_px[1] = 3;
        frame_px[W] = -7;
        frame_px[W+1] = 2;
        send_frame(N, 0, 1'b0);
        set_exp4(32'd3, 32'd0, 32'd0, 32'd0);
        expect_outs(4, "mixed");

        // random 0-3 cycle gaps
        set_frame(0);
        send_frame(N, 3, 1'b0);
        set_exp4(32'd6, 32'd8, 32'd14, 32'd16);
        expect_outs(4, "gaps");

        // aborted partial frame, then restart with frame_start
        for (int k = 0; k < N; k++) frame_px[k] = 1000 + k;
        send_frame(5, 0, 1'b0);
        expect_outs(0, "abort_pre");
        set_frame(0);
        send_frame(N, 0, 1'b1);
        set_exp4(32'd6, 32'd8, 32'd14, 32'd16);
        expect_outs(4, "abort");

        // reset in the middle of a frame
        for (int k = 0; k < N; k++) frame_px[k] = 50 + k;
        send_frame(10, 0, 1'b0);
        exp_v[0] = 32'd55; exp_f[0] = 1'b0;
        exp_v[1] = 32'd57; exp_f[1] = 1'b0;
        expect_outs(2, "pre_rst");
        reset = 1'b1;
        model_out = 32'd0;
        #1;
        check_outputs_zero("rst_async");
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("rst_hold");
        reset = 1'b0;
        set_frame(0);
        send_frame(N, 0, 1'b0);
        set_exp4(32'd6, 32'd8, 32'd14, 32'd16);
        expect_outs(4, "post_rst");

        // back-to-back frames without bubble or frame_start
        set_frame(0);
        send_frame(N, 0, 1'b0);
        set_frame(1);
        send_frame(N, 0, 1'b0);
        set_exp4(32'd6, 32'd8, 32'd14, 32'd16);
        exp_v[4] = 32'd16; exp_v[5] = 32'd14; exp_v[6] = 32'd8; exp_v[7] = 32'd6;
        exp_f[4] = 1'b0;   exp_f[5] = 1'b0;   exp_f[6] = 1'b0;  exp_f[7] = 1'b1;
        expect_outs(8, "b2b");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
